// File: rtl/serial_pair_serializer_msb_first.sv
// Serializes a pair of parallel operands into two MSB-first bit streams with
// a one-cycle comparator-clear pulse ahead of every word.
module serial_pair_serializer_msb_first #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last,
  output logic             cmp_rst
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             transfer;
  logic             beat;
  logic             at_last;

  // Handshake and output decode; everything is held low while in reset.
  always_comb begin
    at_last   = (cnt == LAST_CNT);
    in_ready  = rst_n && ((state == IDLE) ||
                          ((state == SHIFT) && at_last && out_ready));
    transfer  = in_valid && in_ready;
    beat      = rst_n && (state == SHIFT) && out_ready;
    out_valid = rst_n && (state == SHIFT);
    out_a     = out_valid && sh_a[WIDTH-1];
    out_b     = out_valid && sh_b[WIDTH-1];
    out_first = out_valid && (cnt == '0);
    out_last  = out_valid && at_last;
    cmp_rst   = rst_n && (state == CLEAR);
  end

  // State, shift registers and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh_a  <= '0;
      sh_b  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            sh_a  <= in_a;
            sh_b  <= in_b;
            cnt   <= '0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          state <= SHIFT;
        end
        SHIFT: begin
          if (beat) begin
            if (at_last) begin
              // The counter wraps to 0 instead of incrementing past the LSB,
              // so a following word always starts from a clean count.
              cnt <= '0;
              if (transfer) begin
                sh_a  <= in_a;
                sh_b  <= in_b;
                state <= CLEAR;
              end else begin
                sh_a  <= {sh_a[WIDTH-2:0], 1'b0};
                sh_b  <= {sh_b[WIDTH-2:0], 1'b0};
                state <= IDLE;
              end
            end else begin
              sh_a <= {sh_a[WIDTH-2:0], 1'b0};
              sh_b <= {sh_b[WIDTH-2:0], 1'b0};
              cnt  <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_pair_serializer_msb_first.md
SERIAL_PAIR_SERIALIZER_MSB_FIRST -- requirements
Module: serial_pair_serializer_msb_first

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bits per operand (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream presents an operand pair.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts a pair in this cycle.
REQ-006 The block SHALL have ports in_a and in_b, input, WIDTH bits each: parallel operands A and B.
REQ-007 The block SHALL have port out_ready, input, 1 bit: downstream comparator may consume a bit this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_a/out_b carry a valid bit pair.
REQ-009 The block SHALL have ports out_a and out_b, output, 1 bit each: current serial bits of A and B, MSB first.
REQ-010 The block SHALL have port out_first, output, 1 bit: current bit pair is the MSB of the word.
REQ-011 The block SHALL have port out_last, output, 1 bit: current bit pair is the LSB of the word.
REQ-012 The block SHALL have port cmp_rst, output, 1 bit: active-high clear for the downstream MSB-first comparator state.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, CLEAR and SHIFT.
REQ-014 A transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; in_a and in_b SHALL then be captured into WIDTH-bit shift registers sh_a and sh_b, and bit counter cnt SHALL be set to 0.
REQ-015 In IDLE, in_ready SHALL be 1; on a transfer the state SHALL go to CLEAR, otherwise it SHALL stay in IDLE.
REQ-016 In CLEAR, cmp_rst SHALL be 1 for exactly one cycle, out_valid SHALL be 0 and in_ready SHALL be 0, and the state SHALL go unconditionally to SHIFT, independent of out_ready.
REQ-017 In SHIFT, out_valid SHALL be 1, out_a SHALL equal sh_a[WIDTH-1] and out_b SHALL equal sh_b[WIDTH-1].
REQ-018 In SHIFT, out_first SHALL equal (cnt == 0) and out_last SHALL equal (cnt == WIDTH-1).
REQ-019 A bit beat SHALL occur on a rising edge in SHIFT with out_ready = 1; on a beat, sh_a and sh_b SHALL shift left by one with zero fill, and cnt SHALL increment.
REQ-020 In SHIFT with out_ready = 0 (stall), sh_a, sh_b, cnt, state and all outputs SHALL hold their values.
REQ-021 On a beat with cnt == WIDTH-1, the state SHALL go to IDLE, or to CLEAR if a transfer occurs in the same cycle.
REQ-022 in_ready SHALL be 1 in IDLE, and also in SHIFT when cnt == WIDTH-1 and out_ready == 1; in_ready SHALL be 0 in every other case. This gives back-to-back words one CLEAR cycle apart.
REQ-023 Each word SHALL occupy exactly WIDTH beats: latency from the transfer edge to the first out_valid is 2 cycles, and in steady state without stalls the throughput is one word per WIDTH+1 cycles.
REQ-024 cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.
REQ-025 in_a and in_b SHALL be ignored in every cycle without a transfer; changes on them during SHIFT SHALL NOT affect the serial output.
REQ-026 cmp_rst SHALL be 0 whenever the state is not CLEAR; out_first and out_last SHALL be 0 whenever out_valid is 0.

Reset
REQ-027 While rst_n == 0 at a rising edge, the state SHALL become IDLE, cnt SHALL become 0, and sh_a and sh_b SHALL become 0.
REQ-028 While rst_n == 0, in_ready SHALL be forced to 0, and out_valid, out_first, out_last, cmp_rst, out_a and out_b SHALL all be 0.
REQ-029 A reset asserted during CLEAR or SHIFT SHALL abort the word with no further beats; the next word SHALL again be preceded by a CLEAR cycle.

Verification
REQ-030 With WIDTH=4, the bench SHALL apply reset, then a transfer of A=4'b1010 and B=4'b1001 with out_ready=1. Required response: cmp_rst=1 for one cycle, then out_a = 1,0,1,0 and out_b = 1,0,0,1 on 4 consecutive cycles; out_first on beat 0 only, out_last on beat 3 only; then IDLE.
REQ-031 With WIDTH=4, the bench SHALL hold in_valid=1 with words A=4'hF,B=4'h0 followed by A=4'h3,B=4'h3. Required response: in_ready is pulsed on the last beat of the first word; exactly one cmp_rst cycle separates the words; no idle cycle is inserted.
REQ-032 With WIDTH=4, the bench SHALL drop out_ready to 0 for 3 cycles at beat 2. Required response: out_a, out_b, out_first and out_last hold; out_valid stays 1; the word completes with 4 beats total and no bit is lost or repeated.
REQ-033 With WIDTH=4, the bench SHALL drive rst_n=0 for one cycle at beat 1 of a word. Required response: outputs drop to 0 next cycle; state is IDLE with in_ready=1; a new word starts with cmp_rst.
REQ-034 The bench SHALL change in_a and in_b every cycle during SHIFT, with in_valid=0. Required response: the serial stream matches the captured word exactly.
REQ-035 The bench SHALL connect the block to the MSB-first serial comparator, with comparator rst driven by cmp_rst OR NOT rst_n, and apply 200 random WIDTH=8 pairs. Required response: comparator results sampled on out_last match the golden A<B, A==B and A>B for every pair.
